// File: rtl/clk_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_pkg;

    typedef enum logic [1:0] {
        CPU_FAST = 2'b00,
        CPU_SLOW = 2'b01,
        CPU_STEP = 2'b10,
        CPU_HALT = 2'b11
    } cpu_mode_t;

    localparam int DEF_DIV = 49999;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_prog_div_channel.sv
// One programmable divide channel: divisor, counter, tick pulse and square wave.
module div_channel #(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 49999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             sq
);

    logic [DIV_W-1:0] d;
    logic [DIV_W-1:0] c;
    logic [DIV_W-1:0] d_n;
    logic [DIV_W-1:0] c_n;

    // tick is kept equal to (c == d) by registering the look-ahead compare
    always_comb begin
        d_n = we ? div : d;
        c_n = c + 1'b1;
        if (we || tick) c_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d    <= DIV_W'(DEF_DIV);
            c    <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            d    <= d_n;
            c    <= c_n;
            tick <= (c_n == d_n);
            sq   <= sq ^ tick;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Clock divider / enable generator: free counter, divide channels,
// glitch-guarded CPU clock and modulo event counter.
module clk_div_prog #(
    parameter int CNT_W    = 32,
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = clk_pkg::DEF_DIV,
    parameter int FAST_BIT = 2,
    parameter int SLOW_BIT = 25,
    parameter int STEP_HI  = 4,
    parameter int MOD      = 60,
    parameter int MOD_W    = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [clk_pkg::clog2(N_CH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]                 cfg_div,
    input  logic [1:0]                       cpu_mode,
    input  logic                             step_btn,
    output logic [CNT_W-1:0]                 clkdiv,
    output logic [N_CH-1:0]                  ch_tick,
    output logic [N_CH-1:0]                  ch_clk,
    output logic                             cpu_clk,
    output logic                             cpu_ce,
    output logic [MOD_W-1:0]                 mod_cnt,
    output logic                             mod_wrap
);
    import clk_pkg::*;

    localparam int STEP_W = clog2(STEP_HI + 1);

    logic              ch_ok;
    logic [2:0]        sync;
    logic              step_edge;
    logic [STEP_W-1:0] stretch;
    logic              step_src;
    cpu_mode_t         active;
    cpu_mode_t         req;
    logic              src_act;
    logic              src_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clkdiv <= '0;
        else     clkdiv <= clkdiv + 1'b1;
    end

    assign ch_ok = 32'(cfg_ch) < N_CH;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .we   (cfg_we && ch_ok && (32'(cfg_ch) == g)),
            .div  (cfg_div),
            .tick (ch_tick[g]),
            .sq   (ch_clk[g])
        );
    end

    assign step_edge = sync[1] & ~sync[2];
    assign step_src  = (stretch != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            stretch <= '0;
        end else begin
            sync <= {sync[1:0], step_btn};
            if (step_src)       stretch <= stretch - 1'b1;
            else if (step_edge) stretch <= STEP_W'(STEP_HI);
        end
    end

    function automatic logic src_of(input cpu_mode_t m,
                                    input logic [CNT_W-1:0] cd,
                                    input logic st);
        logic s;
        s = 1'b0;
        case (m)
            CPU_FAST: s = cd[FAST_BIT];
            CPU_SLOW: s = cd[SLOW_BIT];
            CPU_STEP: s = st;
            default:  s = 1'b0;
        endcase
        return s;
    endfunction

    assign req     = cpu_mode_t'(cpu_mode);
    assign src_act = src_of(active, clkdiv, step_src);
    assign src_req = src_of(req, clkdiv, step_src);

    // Switch only when old output, old source and new source are all low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= CPU_HALT;
            cpu_clk <= 1'b0;
            cpu_ce  <= 1'b0;
        end else begin
            if (!cpu_clk && !src_act && !src_req) active <= req;
            cpu_clk <= src_act;
            cpu_ce  <= src_act & ~cpu_clk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_cnt  <= '0;
            mod_wrap <= 1'b0;
        end else begin
            mod_wrap <= ch_tick[0] && (mod_cnt == MOD_W'(MOD - 1));
            if (ch_tick[0]) begin
                if (mod_cnt == MOD_W'(MOD - 1)) mod_cnt <= '0;
                else                            mod_cnt <= mod_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: directed stimulus, cycle-stamped
// expectations, negedge monitor.
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [1:0]  cpu_mode = 2'b11;
    logic        step_btn = 1'b0;
    logic [31:0] clkdiv;
    logic [3:0]  ch_tick;
    logic [3:0]  ch_clk;
    logic        cpu_clk;
    logic        cpu_ce;
    logic [5:0]  mod_cnt;
    logic        mod_wrap;

    clk_div_prog dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cpu_mode (cpu_mode),
        .step_btn (step_btn),
        .clkdiv   (clkdiv),
        .ch_tick  (ch_tick),
        .ch_clk   (ch_clk),
        .cpu_clk  (cpu_clk),
        .cpu_ce   (cpu_ce),
        .mod_cnt  (mod_cnt),
        .mod_wrap (mod_wrap)
    );

    always #5 clk = ~clk;

    typedef enum {K_DIV, K_TICK, K_CHCLK, K_CPU, K_CE, K_MOD, K_WRAP,
                  K_CECNT, K_WRAPCNT} kind_t;
    typedef struct {
        int     cyc;
        kind_t  k;
        longint exp;
    } exp_t;

    exp_t sb[$];
    exp_t rest[$];
    int   cyc;
    int   phase = 1;
    int   checks = 0;
    int   errors = 0;
    int   ce_cnt = 0;
    int   wrap_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int c, input kind_t k, input longint e);
        exp_t x;
        x.cyc = c;
        x.k   = k;
        x.exp = e;
        sb.push_back(x);
    endtask

    function automatic longint sample(input kind_t k);
        case (k)
            K_DIV:     return longint'(clkdiv);
            K_TICK:    return longint'(ch_tick);
            K_CHCLK:   return longint'(ch_clk);
            K_CPU:     return longint'(cpu_clk);
            K_CE:      return longint'(cpu_ce);
            K_MOD:     return longint'(mod_cnt);
            K_WRAP:    return longint'(mod_wrap);
            K_CECNT:   return longint'(ce_cnt);
            default:   return longint'(wrap_cnt);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (phase == 1 && cpu_ce && cyc >= 101 && cyc <= 150) ce_cnt++;
            if (phase == 1 && mod_wrap && cyc >= 201 && cyc <= 379) wrap_cnt++;
            rest.delete();
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].cyc == cyc)
                    chk($sformatf("p%0d_c%0d_%s", phase, cyc, sb[i].k.name()),
                        sample(sb[i].k), sb[i].exp);
                else
                    rest.push_back(sb[i]);
            end
            sb = rest;
        end
    end

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clkdiv", longint'(clkdiv), 0);
        chk("rst_tick", longint'(ch_tick), 0);
        chk("rst_cpu", longint'(cpu_clk), 0);
        chk("rst_mod", longint'(mod_cnt), 0);

        push(0, K_DIV, 0);    push(0, K_TICK, 0);  push(0, K_CHCLK, 0);
        push(0, K_CPU, 0);    push(0, K_CE, 0);    push(0, K_MOD, 0);
        push(0, K_WRAP, 0);   push(5, K_DIV, 5);
        push(14, K_TICK, 2);  push(15, K_TICK, 0); push(17, K_TICK, 0);
        push(18, K_TICK, 2);  push(22, K_TICK, 2); push(28, K_TICK, 0);
        push(14, K_CHCLK, 0); push(15, K_CHCLK, 2); push(18, K_CHCLK, 2);
        push(19, K_CHCLK, 0); push(23, K_CHCLK, 2); push(30, K_CHCLK, 0);
        push(30, K_TICK, 2);  push(31, K_TICK, 2); push(32, K_TICK, 2);
        push(31, K_CHCLK, 2); push(32, K_CHCLK, 0); push(33, K_CHCLK, 2);
        push(44, K_CPU, 0);   push(45, K_CPU, 1);  push(48, K_CPU, 1);
        push(49, K_CPU, 0);   push(53, K_CPU, 1);  push(44, K_CE, 0);
        push(45, K_CE, 1);    push(46, K_CE, 0);   push(53, K_CE, 1);
        push(51, K_TICK, 2);
        push(61, K_CPU, 1);   push(64, K_CPU, 1);  push(69, K_CPU, 0);
        push(70, K_CPU, 0);   push(69, K_CE, 0);
        push(113, K_CPU, 0);  push(114, K_CPU, 1); push(117, K_CPU, 1);
        push(118, K_CPU, 0);  push(120, K_CPU, 0); push(114, K_CE, 1);
        push(115, K_CE, 0);   push(134, K_CPU, 1); push(137, K_CPU, 1);
        push(138, K_CPU, 0);  push(134, K_CE, 1);  push(151, K_CECNT, 2);
        push(201, K_TICK, 3); push(201, K_MOD, 0); push(202, K_MOD, 1);
        push(260, K_MOD, 59); push(260, K_WRAP, 0); push(261, K_MOD, 0);
        push(261, K_WRAP, 1); push(262, K_WRAP, 0); push(262, K_MOD, 1);
        push(321, K_WRAP, 1); push(321, K_MOD, 0); push(350, K_DIV, 350);
        push(380, K_WRAPCNT, 2); push(399, K_MOD, 18);

        rst = 1'b0;
        at(10);  cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
        at(11);  cfg_we = 1'b0;
        at(30);  cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd0;
        at(31);  cfg_we = 1'b0;
        at(40);  cpu_mode = 2'b00;
        at(50);  cfg_ch = 2'd2; cfg_div = 16'd0;
        at(60);  cpu_mode = 2'b01;
        at(100); cpu_mode = 2'b10;
        at(110); step_btn = 1'b1;
        at(112); step_btn = 1'b0;
        at(113); step_btn = 1'b1;
        at(114); step_btn = 1'b0;
        at(130); step_btn = 1'b1;
        at(132); step_btn = 1'b0;
        at(200); cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0;
        at(201); cfg_we = 1'b0;
        at(400);
        rst = 1'b1;
        #1;
        chk("async_mod", longint'(mod_cnt), 0);
        chk("async_clkdiv", longint'(clkdiv), 0);
        chk("async_tick", longint'(ch_tick), 0);
        chk("p1_drain", longint'(sb.size()), 0);
        sb.delete();

        phase = 2;
        cpu_mode = 2'b11;
        push(0, K_DIV, 0);        push(0, K_TICK, 0);   push(0, K_MOD, 0);
        push(0, K_CPU, 0);        push(49998, K_TICK, 0);
        push(49999, K_TICK, 15);  push(49999, K_DIV, 49999);
        push(49999, K_MOD, 0);    push(50000, K_TICK, 0);
        push(50000, K_CHCLK, 15); push(50000, K_MOD, 1);
        push(50000, K_WRAP, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        at(50002);
        chk("p2_drain", longint'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
